// File: rtl/pad_share_arbiter.sv
// Round-robin ownership of a shared bidirectional pad group with an all-tristate turnaround
// between owners. Define PAD_SHARE_PREEMPT_EN to force rotation after HOLD_MAX owned cycles.
module pad_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int PAD_W       = 8,
  parameter int TURN_CYC    = 2,
  parameter int HOLD_MAX    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  input  logic [NUM_REQ*PAD_W-1:0]   oe_i,
  input  logic [NUM_REQ*PAD_W-1:0]   out_i,
  output logic [PAD_W-1:0]           in_o,
  output logic [PAD_W-1:0]           pad_oen_o,
  output logic [PAD_W-1:0]           pad_out_o,
  input  logic [PAD_W-1:0]           pad_in_i,
  output logic [$clog2(NUM_REQ)-1:0] owner_o,
  output logic                       busy_o
);
  localparam int OW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_TURN, S_OWN} state_e;

  state_e             state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      rr_q, rr_d;
  logic [3:0]         turn_q, turn_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [PAD_W-1:0]   oen_q, oen_d;
  logic [PAD_W-1:0]   pout_q, pout_d;
  logic [PAD_W-1:0]   sync_q [SYNC_STAGES];
  logic [NUM_REQ-1:0] own_oh;
  logic [NUM_REQ-1:0] others;
  logic               leave;

`ifdef PAD_SHARE_PREEMPT_EN
  localparam int HW = $clog2(HOLD_MAX + 1);
  logic [HW-1:0] hold_q, hold_d;
`endif

  // First asserted request strictly after base, wrapping modulo NUM_REQ.
  function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [OW-1:0] base);
    logic [OW-1:0] pick;
    logic          found;
    pick  = base;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(base) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        pick  = OW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    turn_d  = turn_q;
    own_oh  = NUM_REQ'(1) << owner_q;
    others  = req_i & ~own_oh;
    leave   = !req_i[owner_q];
`ifdef PAD_SHARE_PREEMPT_EN
    if (hold_q >= HW'(HOLD_MAX) && |others) leave = 1'b1;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          owner_d = rr_pick(req_i, rr_q);
          state_d = (TURN_CYC == 0) ? S_OWN : S_TURN;
          turn_d  = 4'(TURN_CYC);
        end
      end
      S_TURN: begin
        if (turn_q <= 4'd1) begin
          state_d = req_i[owner_q] ? S_OWN : S_IDLE;
          turn_d  = '0;
        end else begin
          turn_d = turn_q - 4'd1;
        end
      end
      S_OWN: begin
        // Handover always goes through TURN so the pads see a tristate gap.
        if (leave) begin
          if (|others) begin
            owner_d = rr_pick(others, rr_q);
            state_d = S_TURN;
            turn_d  = 4'(TURN_CYC);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_OWN && state_q != S_OWN) rr_d = owner_d;

    gnt_d  = '0;
    oen_d  = '1;
    pout_d = '0;
    if (state_d == S_OWN) begin
      gnt_d  = NUM_REQ'(1) << owner_d;
      oen_d  = ~oe_i[int'(owner_d)*PAD_W +: PAD_W];
      pout_d = out_i[int'(owner_d)*PAD_W +: PAD_W];
    end

`ifdef PAD_SHARE_PREEMPT_EN
    hold_d = '0;
    if (state_d == S_OWN) begin
      if (state_q != S_OWN)              hold_d = HW'(1);
      else if (hold_q >= HW'(HOLD_MAX))  hold_d = hold_q;
      else                               hold_d = hold_q + HW'(1);
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst_i) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      rr_q    <= OW'(NUM_REQ - 1);
      turn_q  <= '0;
      gnt_q   <= '0;
      oen_q   <= '1;
      pout_q  <= '0;
`ifdef PAD_SHARE_PREEMPT_EN
      hold_q  <= '0;
`endif
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      turn_q  <= turn_d;
      gnt_q   <= gnt_d;
      oen_q   <= oen_d;
      pout_q  <= pout_d;
`ifdef PAD_SHARE_PREEMPT_EN
      hold_q  <= hold_d;
`endif
      sync_q[0] <= pad_in_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign gnt_o     = gnt_q;
  assign pad_oen_o = oen_q;
  assign pad_out_o = pout_q;
  assign owner_o   = owner_q;
  assign busy_o    = (state_q != S_IDLE);
  assign in_o      = sync_q[SYNC_STAGES-1];

endmodule
